sine_tone_detector: RTL and testbench



---
 rtl/sine_tone_detector.sv | 229 ++++++++++++++++++++++
 tb/tb_sine_tone_detector.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_tone_detector.sv
// Rising mid-scale crossing detector with hysteresis: measures the tone period
// in clock cycles, classifies it into a 2-bit frequency code and tracks lock.
// Optional build macro TONE_DETECT_AMPLITUDE_EN adds a per-period peak-to-peak output.
module sine_tone_detector #(
    parameter int unsigned MID        = 32'd32768,
    parameter int unsigned HYST       = 32'd1024,
    parameter int unsigned LOCK_COUNT = 32'd2,
    parameter int unsigned TIMEOUT    = 32'd3000000,
    parameter int unsigned T1600_MIN  = 32'd150000,
    parameter int unsigned T800_MIN   = 32'd300000,
    parameter int unsigned T400_MIN   = 32'd600000,
    parameter int unsigned T200_MIN   = 32'd1200000,
    parameter int unsigned T200_MAX   = 32'd2400000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        sample_valid,
    input  logic [15:0] sample,
    output logic [1:0]  frequency,
    output logic        locked,
    output logic [23:0] period,
    output logic        period_valid
`ifdef TONE_DETECT_AMPLITUDE_EN
    ,
    output logic [15:0] amplitude
`endif
);

    typedef enum logic [1:0] {
        ACQUIRE    = 2'd0,
        TRACK_HIGH = 2'd1,
        TRACK_LOW  = 2'd2
    } state_e;

    localparam logic [15:0] LOW_TH  = 16'(MID - HYST);
    localparam logic [15:0] HIGH_TH = 16'(MID + HYST);
    localparam logic [23:0] CNT_MAX = 24'hFF_FFFF;
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_COUNT);

    // Result is {valid, code}; an out-of-range period returns valid=0.
    function automatic logic [2:0] classify(input logic [23:0] p);
        logic [31:0] w;
        logic [2:0]  r;
        w = {8'd0, p};
        if (w >= T1600_MIN && w < T800_MIN) begin
            r = 3'b111;
        end else if (w >= T800_MIN && w < T400_MIN) begin
            r = 3'b110;
        end else if (w >= T400_MIN && w < T200_MIN) begin
            r = 3'b101;
        end else if (w >= T200_MIN && w <= T200_MAX) begin
            r = 3'b100;
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    state_e      state_q, state_d;
    logic [23:0] counter_q, counter_d;
    logic        armed_q, armed_d;
    logic [3:0]  agree_q, agree_d;
    logic [1:0]  prev_code_q, prev_code_d;
    logic        prev_ok_q, prev_ok_d;
    logic [1:0]  freq_q, freq_d;
    logic        locked_q, locked_d;
    logic [23:0] period_q, period_d;
    logic        pv_q, pv_d;

    logic        is_low_s, is_high_s, tracking_s, timeout_s;
    logic        first_cross_s, cross_s;
    logic [23:0] counter_inc_s;
    logic [2:0]  cls_s;

    assign is_low_s      = sample_valid && (sample < LOW_TH);
    assign is_high_s     = sample_valid && (sample >= HIGH_TH);
    assign tracking_s    = (state_q != ACQUIRE);
    assign timeout_s     = tracking_s && ({8'd0, counter_q} >= TIMEOUT);
    assign counter_inc_s = (counter_q == CNT_MAX) ? counter_q : counter_q + 24'd1;
    assign cls_s         = classify(counter_inc_s);
    assign first_cross_s = (state_q == ACQUIRE) && armed_q && is_high_s;
    assign cross_s       = !timeout_s && (state_q == TRACK_LOW) && is_high_s;

    // Next-state: crossing FSM, period counter, classification and lock tracking.
    always_comb begin
        state_d     = state_q;
        counter_d   = counter_q;
        armed_d     = armed_q;
        agree_d     = agree_q;
        prev_code_d = prev_code_q;
        prev_ok_d   = prev_ok_q;
        freq_d      = freq_q;
        locked_d    = locked_q;
        period_d    = period_q;
        pv_d        = 1'b0;

        if (timeout_s) begin
            state_d   = ACQUIRE;
            counter_d = 24'd0;
            armed_d   = 1'b0;
            agree_d   = 4'd0;
            locked_d  = 1'b0;
        end else begin
            counter_d = tracking_s ? counter_inc_s : counter_q;
            case (state_q)
                ACQUIRE: begin
                    if (is_low_s) begin
                        armed_d = 1'b1;
                    end else if (first_cross_s) begin
                        counter_d = 24'd0;
                        state_d   = TRACK_HIGH;
                    end else begin
                        armed_d = armed_q;
                    end
                end
                TRACK_HIGH: begin
                    state_d = is_low_s ? TRACK_LOW : TRACK_HIGH;
                end
                TRACK_LOW: begin
                    if (cross_s) begin
                        period_d  = counter_inc_s;
                        pv_d      = 1'b1;
                        counter_d = 24'd0;
                        state_d   = TRACK_HIGH;
                        if (!cls_s[2]) begin
                            agree_d   = 4'd0;
                            locked_d  = 1'b0;
                            prev_ok_d = 1'b0;
                        end else begin
                            if (prev_ok_q && (cls_s[1:0] == prev_code_q)) begin
                                agree_d = (agree_q >= LOCK_N) ? LOCK_N : agree_q + 4'd1;
                            end else begin
                                agree_d = 4'd1;
                            end
                            prev_ok_d   = 1'b1;
                            prev_code_d = cls_s[1:0];
                            if (agree_d >= LOCK_N) begin
                                locked_d = 1'b1;
                                freq_d   = cls_s[1:0];
                            end else begin
                                locked_d = 1'b0;
                            end
                        end
                    end else begin
                        state_d = TRACK_LOW;
                    end
                end
                default: begin
                    state_d = ACQUIRE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ACQUIRE;
            counter_q   <= 24'd0;
            armed_q     <= 1'b0;
            agree_q     <= 4'd0;
            prev_code_q <= 2'd0;
            prev_ok_q   <= 1'b0;
            freq_q      <= 2'd0;
            locked_q    <= 1'b0;
            period_q    <= 24'd0;
            pv_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            armed_q     <= armed_d;
            agree_q     <= agree_d;
            prev_code_q <= prev_code_d;
            prev_ok_q   <= prev_ok_d;
            freq_q      <= freq_d;
            locked_q    <= locked_d;
            period_q    <= period_d;
            pv_q        <= pv_d;
        end
    end

    assign frequency    = freq_q;
    assign locked       = locked_q;
    assign period       = period_q;
    assign period_valid = pv_q;

`ifdef TONE_DETECT_AMPLITUDE_EN
    logic [15:0] min_q, min_d, max_q, max_d, amp_q, amp_d;
    logic [15:0] min_upd_s, max_upd_s;

    assign min_upd_s = (sample < min_q) ? sample : min_q;
    assign max_upd_s = (sample > max_q) ? sample : max_q;

    // Running min/max per period; the crossing sample closes one period and seeds the next.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        amp_d = amp_q;
        if (timeout_s) begin
            amp_d = 16'd0;
        end else if (first_cross_s || cross_s) begin
            amp_d = cross_s ? (max_upd_s - min_upd_s) : amp_q;
            min_d = sample;
            max_d = sample;
        end else if (tracking_s && sample_valid) begin
            min_d = min_upd_s;
            max_d = max_upd_s;
        end else begin
            amp_d = amp_q;
        end
    end

    // Amplitude registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            min_q <= 16'd0;
            max_q <= 16'd0;
            amp_q <= 16'd0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
            amp_q <= amp_d;
        end
    end

    assign amplitude = amp_q;
`endif

endmodule

// File: tb/tb_sine_tone_detector.sv
// Directed-vector bench for sine_tone_detector with a period/lock reference model
// and time-scaled thresholds (all periods divided by 1000) to keep runs short.
module tb_sine_tone_detector;

    localparam int MID = 32768;
    localparam int HYST = 1024;
    localparam int LC = 2;
    localparam int TMO = 3000;
    localparam int T1 = 150;
    localparam int T2 = 300;
    localparam int T3 = 600;
    localparam int T4 = 1200;
    localparam int T5 = 2400;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample = 16'd0;
    logic [1:0]  frequency;
    logic        locked;
    logic [23:0] period;
    logic        period_valid;
`ifdef TONE_DETECT_AMPLITUDE_EN
    logic [15:0] amplitude;
`endif

    int n_err = 0;
    int n_chk = 0;

    always #5 clock = ~clock;

    sine_tone_detector #(
        .MID(MID), .HYST(HYST), .LOCK_COUNT(LC), .TIMEOUT(TMO),
        .T1600_MIN(T1), .T800_MIN(T2), .T400_MIN(T3), .T200_MIN(T4), .T200_MAX(T5)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .sample_valid(sample_valid),
        .sample(sample),
        .frequency(frequency),
        .locked(locked),
        .period(period),
        .period_valid(period_valid)
`ifdef TONE_DETECT_AMPLITUDE_EN
        ,
        .amplitude(amplitude)
`endif
    );

    // Reference model: event-time based, crossing times are cycle stamps.
    int cyc = 0;
    int last_cross = 0;
    bit tracking = 1'b0;
    bit armed = 1'b0;
    bit seen_low = 1'b0;
    int run_len = 0;
    int run_cls = 0;
    int exp_pv = 0;
    int exp_period = 0;
    int exp_locked = 0;
    int exp_freq = 0;
    int exp_amp = 0;
    int mn = 0;
    int mx = 0;

    logic [15:0] lut [64];
    int idx = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int classify_p(input int p);
        if (p >= T1 && p < T2) return 3;
        if (p >= T2 && p < T3) return 2;
        if (p >= T3 && p < T4) return 1;
        if (p >= T4 && p <= T5) return 0;
        return -1;
    endfunction

    task automatic model_reset();
        tracking = 1'b0; armed = 1'b0; seen_low = 1'b0; run_len = 0;
        exp_pv = 0; exp_period = 0; exp_locked = 0; exp_freq = 0; exp_amp = 0;
    endtask

    task automatic model_step();
        int s, p, c;
        bit lo, hi;
        cyc++;
        exp_pv = 0;
        s = int'(sample);
        lo = (s < MID - HYST);
        hi = (s >= MID + HYST);
        if (tracking && (cyc - last_cross - 1) >= TMO) begin
            tracking = 1'b0; armed = 1'b0; run_len = 0; exp_locked = 0; exp_amp = 0;
        end else if (sample_valid) begin
            if (!tracking) begin
                if (lo) armed = 1'b1;
                else if (hi && armed) begin
                    tracking = 1'b1; seen_low = 1'b0; last_cross = cyc; mn = s; mx = s;
                end
            end else begin
                if (s < mn) mn = s;
                if (s > mx) mx = s;
                if (lo) seen_low = 1'b1;
                else if (hi && seen_low) begin
                    p = cyc - last_cross;
                    if (p > 24'hFFFFFF) p = 24'hFFFFFF;
                    exp_period = p;
                    exp_pv = 1;
                    c = classify_p(p);
                    if (c < 0) begin
                        run_len = 0; exp_locked = 0;
                    end else begin
                        if (run_len > 0 && c == run_cls) run_len++;
                        else run_len = 1;
                        run_cls = c;
                        exp_locked = (run_len >= LC) ? 1 : 0;
                        if (exp_locked == 1) exp_freq = c;
                    end
                    exp_amp = mx - mn;
                    mn = s; mx = s;
                    last_cross = cyc;
                    seen_low = 1'b0;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // Every-cycle comparison of the DUT against the model.
    initial begin
        forever begin
            @(negedge clock);
            chk("period_valid", int'(period_valid), exp_pv);
            chk("period", int'(period), exp_period);
            chk("locked", int'(locked), exp_locked);
            chk("frequency", int'(frequency), exp_freq);
`ifdef TONE_DETECT_AMPLITUDE_EN
            chk("amplitude", int'(amplitude), exp_amp);
`endif
        end
    end

    task automatic feed(input int stride, input int n);
        for (int k = 0; k < n; k++) begin
            sample_valid = 1'b1;
            sample = lut[idx];
            idx = (idx + 1) % 64;
            @(posedge clock); #2;
            sample_valid = 1'b0;
            repeat (stride - 1) begin
                @(posedge clock); #2;
            end
        end
    endtask

    task automatic feed_val(input logic [15:0] v, input int gap);
        sample_valid = 1'b1;
        sample = v;
        @(posedge clock); #2;
        sample_valid = 1'b0;
        repeat (gap - 1) begin
            @(posedge clock); #2;
        end
    endtask

    task automatic expect_out(input string nm, input int per, input int lk, input int fr);
        chk({nm, "_period"}, int'(period), per);
        chk({nm, "_locked"}, int'(locked), lk);
        chk({nm, "_freq"}, int'(frequency), fr);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            lut[i] = 16'($rtoi(32768.0 + 32767.0 * $sin(2.0 * 3.14159265358979 * i / 64.0) + 0.5));
        end
        repeat (3) @(posedge clock);
        #2;
        expect_out("reset", 0, 0, 0);
        chk("reset_pv", int'(period_valid), 0);
        reset_n = 1'b1;
        @(posedge clock); #2;

        // Code 3: stride 4 -> period 256
        feed(4, 194);
        expect_out("code3", 256, 1, 3);
`ifdef TONE_DETECT_AMPLITUDE_EN
        chk("amp_near_fullscale", (int'(amplitude) >= 65534 - 64) ? 1 : 0, 1);
`endif
        // Switch to code 1 (stride 13): first period drops lock, second regains
        feed(13, 64);
        expect_out("chg1", 823, 0, 3);
        feed(13, 64);
        expect_out("chg2", 832, 1, 1);

        // Code 2 (stride 7 -> 448) and code 0 (stride 25 -> 1600)
        feed(7, 128);
        expect_out("code2", 448, 1, 2);
        feed(25, 128);
        expect_out("code0", 1600, 1, 0);

        // Reset mid-measurement
        feed(4, 30);
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        expect_out("midreset", 0, 0, 0);
        reset_n = 1'b1;
        idx = 0;
        feed(4, 66);
        expect_out("first_after_reset", 0, 0, 0);

        // Lock again, then in-band noise until the timeout drops lock
        feed(4, 128);
        expect_out("relock", 256, 1, 3);
        for (int k = 0; k < 400; k++) begin
            feed_val(16'(MID + 1000), 4);
            feed_val(16'(MID - 1000), 4);
        end
        expect_out("timeout", 256, 0, 3);
        idx = 0;
        feed(5, 66);
        expect_out("acquire_after_timeout", 256, 0, 3);

        // Out-of-range period 100 at the exact hysteresis edges
        for (int k = 0; k < 6; k++) begin
            feed_val(16'(MID - HYST - 1), 50);
            feed_val(16'(MID + HYST), 50);
        end
        expect_out("short_period", 100, 0, 3);
        // A sample exactly at MID-HYST is not low, so no crossing follows
        for (int k = 0; k < 2; k++) begin
            feed_val(16'(MID - HYST), 50);
            feed_val(16'(MID + HYST), 50);
        end
        expect_out("band_edge", 100, 0, 3);

        @(negedge clock);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
